// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Entry fields are sized for the widest supported configuration (AW <= 5, DEPTH <= 15).
package pipe_pkg;

    localparam int SB_AW    = 5;
    localparam int SB_LW    = 4;

    localparam int FWD_RF   = 0;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    function automatic int FWD_WB(input int depth);
        return depth + 1;
    endfunction

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic [SB_LW-1:0] lat;
    } sb_entry_t;

endpackage

// File: rtl/sb_operand_lookup.sv
// Youngest-match search and readiness check for one source operand.
// Produces a forwarding code, or a hazard when the youngest producer is not yet forwardable.
module sb_operand_lookup
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int FW    = 3
) (
    input  logic [AW-1:0] rs,
    input  logic          used,
    input  logic          use_ex,
    input  sb_entry_t     slots [DEPTH],
    output logic [FW-1:0] fwd,
    output logic          hazard
);

    logic found;

    always_comb begin
        fwd    = FW'(FWD_RF);
        hazard = 1'b0;
        found  = 1'b0;
        if (used && rs != '0) begin
            // Lowest slot index is the youngest producer; older WAW entries are shadowed.
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && slots[k].valid && slots[k].rd == SB_AW'(rs)) begin
                    found = 1'b1;
                    if (int'(slots[k].lat) <= k + int'(use_ex))
                        fwd = FW'(k + 1 + int'(use_ex));
                    else
                        hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writes: ID stall, operand
// forwarding selects, IF/ID flush qualification and a hazard-stall counter.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int DEPTH = 3,
    parameter int LW    = $clog2(DEPTH + 1),
    parameter int FW    = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_use_ex,
    input  logic             id_we,
    input  logic [AW-1:0]    id_rd,
    input  logic [LW-1:0]    id_lat,
    input  logic             hold,
    input  logic             redirect,
    output logic             stall_id,
    output logic             if_id_flush,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [DEPTH-1:0] slot_valid,
    output logic [31:0]      stall_cnt
);

    sb_entry_t slots_q [DEPTH];
    sb_entry_t new_entry;
    logic      haz_a;
    logic      haz_b;
    logic      hazard;

    sb_operand_lookup #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_lookup_a (
        .rs     (id_rs1),
        .used   (id_rs1_used),
        .use_ex (id_use_ex),
        .slots  (slots_q),
        .fwd    (fwd_a),
        .hazard (haz_a)
    );

    sb_operand_lookup #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_lookup_b (
        .rs     (id_rs2),
        .used   (id_rs2_used),
        .use_ex (id_use_ex),
        .slots  (slots_q),
        .fwd    (fwd_b),
        .hazard (haz_b)
    );

    // Stall contract: while stall_id is high the ID instruction is not accepted and a
    // bubble enters slot 0; a redirect is honoured only on a cycle where ID advances.
    assign hazard      = haz_a | haz_b;
    assign stall_id    = hold | (id_valid & hazard);
    assign if_id_flush = redirect & ~stall_id;

    always_comb begin
        new_entry.valid = id_valid & id_we & (id_rd != '0) & ~stall_id;
        new_entry.rd    = SB_AW'(id_rd);
        new_entry.lat   = SB_LW'(id_lat);
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            slot_valid[k] = slots_q[k].valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                slots_q[k] <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            slots_q[0] <= new_entry;
            for (int k = 1; k < DEPTH; k++)
                slots_q[k] <= slots_q[k-1];
            if (id_valid && hazard && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a driver applies one ID vector per cycle and
// queues the hand-computed outputs; a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
    import pipe_pkg::*;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LW    = 2;
    localparam int FW    = 3;
    localparam int W     = 2 + 2*FW + DEPTH + 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [AW-1:0]    id_rs1 = '0;
    logic [AW-1:0]    id_rs2 = '0;
    logic             id_rs1_used = 1'b0;
    logic             id_rs2_used = 1'b0;
    logic             id_use_ex = 1'b0;
    logic             id_we = 1'b0;
    logic [AW-1:0]    id_rd = '0;
    logic [LW-1:0]    id_lat = '0;
    logic             hold = 1'b0;
    logic             redirect = 1'b0;
    logic             stall_id;
    logic             if_id_flush;
    logic [FW-1:0]    fwd_a;
    logic [FW-1:0]    fwd_b;
    logic [DEPTH-1:0] slot_valid;
    logic [31:0]      stall_cnt;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_compared = 0;
    int           n_mismatched = 0;

    hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_use_ex   (id_use_ex),
        .id_we       (id_we),
        .id_rd       (id_rd),
        .id_lat      (id_lat),
        .hold        (hold),
        .redirect    (redirect),
        .stall_id    (stall_id),
        .if_id_flush (if_id_flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .slot_valid  (slot_valid),
        .stall_cnt   (stall_cnt)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic ex, input logic we,
                        input logic [AW-1:0] rd, input logic [LW-1:0] lat,
                        input logic h, input logic r);
        @(posedge clk);
        #1;
        id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;
        id_rs1_used = u1;  id_rs2_used = u2;  id_use_ex = ex;
        id_we = we;  id_rd = rd;  id_lat = lat;
        hold = h;  redirect = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_out(input string nm, input logic st, input logic fl,
                              input logic [FW-1:0] fa, input logic [FW-1:0] fb,
                              input logic [DEPTH-1:0] sv, input logic [31:0] cnt);
        exp_q.push_back({st, fl, fa, fb, sv, cnt});
        name_q.push_back(nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        string        nm;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {stall_id, if_id_flush, fwd_a, fwd_b, slot_valid, stall_cnt};
            n_compared++;
            if (act !== exp_v) begin
                n_mismatched++;
                $display("FAIL %s: got stall=%0b flush=%0b fa=%0d fb=%0d sv=%b cnt=%0d, want stall=%0b flush=%0b fa=%0d fb=%0d sv=%b cnt=%0d",
                         nm, act[W-1], act[W-2], act[W-3 -: FW], act[W-3-FW -: FW],
                         act[32 +: DEPTH], act[31:0],
                         exp_v[W-1], exp_v[W-2], exp_v[W-3 -: FW], exp_v[W-3-FW -: FW],
                         exp_v[32 +: DEPTH], exp_v[31:0]);
            end
        end
    end

    // Directed stimulus
    initial begin
        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset", 0, 0, 0, 0, 3'b000, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(2);

        // add x5 then sub x6,x5,x0 in EX: forward from EX/MEM
        step(1, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0);
        expect_out("alu_producer", 0, 0, 0, 0, 3'b000, 0);
        step(1, 5, 0, 1, 1, 1, 1, 6, 1, 0, 0);
        expect_out("alu_fwd", 0, 0, 2, 0, 3'b001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("shift_two", 0, 0, 0, 0, 3'b011, 0);
        idle(3);

        // load-use: one stall, then forward from MEM/WB
        step(1, 0, 0, 0, 0, 1, 1, 5, 2, 0, 0);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("load_use_stall", 1, 0, 0, 0, 3'b001, 0);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("load_use_fwd", 0, 0, 3, 0, 3'b010, 1);
        idle(3);

        // branch in ID on fresh ALU result: flush masked while stalled
        step(1, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0);
        step(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1);
        expect_out("branch_stall", 1, 0, 0, 0, 3'b001, 1);
        step(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1);
        expect_out("branch_flush", 0, 1, 2, 2, 3'b010, 2);
        idle(3);

        // WAW: the younger producer wins
        step(1, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0);
        expect_out("waw_second", 0, 0, 0, 0, 3'b001, 2);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("waw_youngest", 0, 0, 2, 0, 3'b011, 2);
        idle(3);

        // latency = DEPTH: two-cycle stall, then WB-data forward
        step(1, 0, 0, 0, 0, 1, 1, 9, 3, 0, 0);
        step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("lat3_stall1", 1, 0, 0, 0, 3'b001, 2);
        step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("lat3_stall2", 1, 0, 0, 0, 3'b010, 3);
        step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("lat3_wb_fwd", 0, 0, 3'(FWD_WB(DEPTH)), 0, 3'b100, 4);
        idle(3);

        // writes to x0 are never tracked
        step(1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        expect_out("x0_no_stall", 0, 0, 0, 0, 3'b000, 4);
        idle(3);

        // hold freezes slots and counter; redirect suppressed
        step(1, 0, 0, 0, 0, 1, 1, 7, 2, 0, 0);
        expect_out("hold_producer", 0, 0, 0, 0, 3'b000, 4);
        for (int i = 0; i < 3; i++) begin
            step(1, 7, 0, 1, 0, 1, 0, 0, 0, 1, 1);
            expect_out("hold_frozen", 1, 0, 0, 0, 3'b001, 4);
        end
        step(1, 7, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        expect_out("hold_release_stall", 1, 0, 0, 0, 3'b001, 4);
        step(1, 7, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        expect_out("hold_release_fwd", 0, 1, 3, 0, 3'b010, 5);
        idle(3);

        // reset asserted in the middle of a load-use stall
        step(1, 0, 0, 0, 0, 1, 1, 5, 2, 0, 0);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_out("pre_reset_stall", 1, 0, 0, 0, 3'b001, 5);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        expect_out("mid_stall_reset", 0, 0, 0, 0, 3'b000, 0);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_out("post_reset_issue", 0, 0, 0, 0, 3'b000, 0);

        // Final report
        idle(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the pipelined RV32 core. It tracks every in-flight register write in a shift-register scoreboard with one slot per post-ID pipeline register. From that it decides ID-stage stalls, per-operand forwarding sources and IF/ID flush qualification. It generalises the fixed 5-stage forward/stall logic to configurable depth and per-instruction result latency, and adds external hold and a stall performance counter.

## Interface
- `NREG`, 32: architectural register count; x0 is never tracked.
- `AW`, $clog2(NREG): register index width.
- `DEPTH`, 3: scoreboard slots. Slot 0 = ID/EX, slot 1 = EX/MEM, slot 2 = MEM/WB, and so on.
- `LW`, $clog2(DEPTH+1): latency field width.
- `FW`, $clog2(DEPTH+2): forwarding-select width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  AW  source indices.
- `id_rs1_used`, `id_rs2_used`  in  1  operand actually read.
- `id_use_ex`  in  1  operands consumed in EX (1) or in ID (0; branch/jalr).
- `id_we`  in  1  instruction writes `id_rd`.
- `id_rd`  in  AW  destination.
- `id_lat`  in  LW  slot at which result first becomes forwardable (ALU 1, load 2); legal range 1..DEPTH.
- `hold`  in  1  external freeze (memory busy).
- `redirect`  in  1  ID resolved taken branch/jal/jalr.
- `stall_id`  out  1  hold PC and IF/ID; bubble into slot 0.
- `if_id_flush`  out  1  qualified redirect; kill IF/ID.
- `fwd_a`, `fwd_b`  out  FW  source code: 0 = register file, c = pipeline register of slot c-1, DEPTH+1 = WB write data.
- `slot_valid`  out  DEPTH  occupancy per slot.
- `stall_cnt`  out  32  hazard-stall cycle count.

## Operation
- Slot entry: valid, rd, lat. Entries are created only when `id_valid & id_we & id_rd!=0`; all other issues enter as a bubble.
- Shift every cycle unless `hold`: slot k moves to slot k+1, and the last slot retires. Slot 0 receives the ID instruction if `~stall_id`, otherwise a bubble.
- Per used operand, scan slots 0..DEPTH-1 for valid entries with a matching rd. The youngest (lowest k) match wins.
- Readiness of the winning match at slot k: ready iff `lat <= k + id_use_ex`.
  - Ready: `fwd = k + 1 + id_use_ex`.
  - Not ready: raise hazard.
  - No match: `fwd = 0`.
- Unused operands and index 0 never match; their fwd is 0.
- `stall_id = hold | (id_valid & hazard)`.
- `if_id_flush = redirect & ~stall_id`. A redirect from a stalled instruction is computed on stale operands and is masked.
- `stall_cnt` increments on cycles with `id_valid & hazard & ~hold`. It saturates at 32'hFFFFFFFF.
- During `hold`, slot contents and `stall_cnt` are frozen; fwd outputs still evaluate combinationally.

## Timing
- Reset (async assert, sync to clk on deassert): all slots invalid, `stall_cnt=0`. Consequently `slot_valid=0`, `fwd_a=fwd_b=0`, and `stall_id=if_id_flush=0` when `hold=0`.
- `stall_id`, `fwd_*` and `if_id_flush` are combinational from ID inputs and registered slots. No added latency.
- A hazard stall lasts exactly `lat - (k + id_use_ex)` cycles, during which bubbles shift in.
- Reset asserted mid-stall clears all in-flight entries immediately. The first post-reset issue sees no hazard.
- Simultaneous `hold` and `redirect`: the flush is suppressed. The redirect must be re-presented when hold drops.
- Two matches in the same cycle: the youngest wins, so a WAW-older value is never forwarded.

## Structure
- Package `pipe_pkg`: forwarding code constants `FWD_RF=0` and `FWD_WB(DEPTH)`, latency constants `LAT_ALU=1` and `LAT_LOAD=2`, and the slot entry struct.
- One sub-module, `sb_operand_lookup`: a priority match and readiness check for one operand, instantiated twice. The shift register and counter live in the top level.

## Test plan
- `add x5` issued cycle t (lat 1); t+1 `sub x6,x5,x0` with use_ex -> no stall, `fwd_a=2`.
- `lw x5` at t (lat 2); t+1 dependent use_ex -> `stall_id=1` for 1 cycle, `stall_cnt=1`; t+2 -> `fwd_a=3`.
- `add x5` at t; t+1 `beq x5,x5` with use_id -> stall 1 cycle; t+2 -> `fwd_a=fwd_b=2`. `redirect=1` during the stall gives `if_id_flush=0`; after the stall it gives `if_id_flush=1`.
- `add x5` at t, `add x5` at t+1, consumer at t+2 use_ex -> `fwd_a=2` (younger producer), not 3.
- `hold=1` for 3 cycles with `lw x7` in slot 0 -> `slot_valid` unchanged, `stall_id=1`, `stall_cnt` unchanged.
- `rst_n` low mid-stall -> `slot_valid=0`, `stall_cnt=0`, and `stall_id=0` within the same cycle. Writes to x0 never stall.
